trng_harvester: RTL and testbench
=================================

Name: trng_harvester

Overview:
Parametrised entropy harvester for the biased-oscillator TRNG. It samples NUM_CH asynchronous biased-ring-oscillator outputs through per-channel synchronisers, then conditions them (raw, XOR-fold or von Neumann). It packs the conditioned bits into WORD_W-bit words and buffers them in a small FIFO with a valid/ready output. A sticky repetition-count health test blocks output when the source sticks.

Parameters:
NUM_CH, 4, number of raw oscillator channels (>=1)
WORD_W, 8, output word width in bits (>=2)
SYNC_STAGES, 2, synchroniser flops per channel (>=2)
FIFO_DEPTH, 4, output FIFO entries (power of 2, >=2)
REP_LIMIT, 16, consecutive identical conditioned bits that trip health_fail (>=2)

Ports:
clk  in  1  system clock
rst_n  in  1  reset; asynchronous, active-low
en  in  1  harvest enable
mode  in  2  0=raw ch0, 1=XOR of all channels, 2=von Neumann on ch0, 3=reserved (behaves as 1)
raw_in  in  NUM_CH  asynchronous oscillator bits
clr_fail  in  1  single-cycle pulse; clears health_fail and overflow
out_data  out  WORD_W  FIFO head word
out_valid  out  1  FIFO non-empty
out_ready  in  1  consumer accepts head when high with out_valid
fifo_count  out  clog2(FIFO_DEPTH)+1  occupied entries
health_fail  out  1  sticky health-test failure
overflow  out  1  sticky: a completed word was dropped

Behaviour:
- Reset (async, rst_n=0): sync flops, shift reg, bit counter, VN phase/stored bit, rep counter, FIFO pointers = 0. out_valid=0, out_data=0, fifo_count=0, health_fail=0, overflow=0.
- Synchroniser: SYNC_STAGES flops per channel. s[i] = last stage. Raw-to-conditioned latency = SYNC_STAGES cycles.
- Conditioned-bit generation (only when en=1 and health_fail=0):
  - mode 0: b = s[0], one bit every cycle.
  - mode 1/3: b = XOR of s[0..NUM_CH-1], one bit every cycle.
  - mode 2: phase toggles each en cycle. Phase 0 stores s[0]. Phase 1 compares s[0] with the stored bit: if they differ, emit b = stored bit; if equal, emit nothing. 01->0, 10->1, 00/11 discarded.
- Packer: each emitted b shifts in at bit 0 (sr = {sr[WORD_W-2:0], b}), so the first bit lands in the MSB. When the WORD_W-th bit arrives, {sr, b} is the completed word in that same cycle. The bit counter returns to 0.
- Word push: the completed word is written to the FIFO on the next edge if the FIFO is not full, or if it is full and a pop occurs in the same cycle. Otherwise the word is dropped and overflow is set.
- FIFO: pop = out_valid & out_ready. Simultaneous push and pop leaves the count unchanged. out_data is the registered head, stable while out_valid=1 and out_ready=0. When the FIFO is empty, out_data holds its last value.
- Health test: the rep counter tracks the run length of identical emitted b values, restarting at 1 on a change. When the run reaches REP_LIMIT, health_fail is set the next cycle.
  - The word containing the REP_LIMIT-th bit is not pushed.
  - While health_fail=1, generation, packing and the rep counter freeze. The partial word is discarded and the bit counter is reset.
  - The FIFO still drains.
- clr_fail: clears health_fail and overflow, and resets the rep counter, bit counter and VN phase. If a trip and clr_fail coincide, clr_fail wins.
- en=0: generation stops, the VN phase resets to 0, the partial word and rep counter are held, and the FIFO still drains.
- mode change, detected against a registered copy: the bit counter, VN phase and rep counter reset next cycle; the partial word is discarded.
- Burst limit: at most one word push per cycle. Worst-case raw rate is 1 word per WORD_W cycles.

Test Plan:
- Reset mid-operation: FIFO holding 3 words, bit counter=5; drop rst_n asynchronously between edges -> all outputs 0 immediately, fifo_count=0, no further pushes until en is reasserted.
- Raw packing: mode=0, en=1, out_ready=1, ch0 driven 1,0,1,1,0,0,1,0 (after SYNC_STAGES) -> one word 8'hB2, out_valid high for exactly 1 cycle.
- Von Neumann: mode=2, ch0 pairs 01,10,11,00,10,01,01,10,10,01 -> 8 emitted bits 0,1,1,0,0,1,1,0 -> word 8'h66; 11 and 00 pairs produce no bit.
- XOR and backpressure: mode=1, NUM_CH=4, channels constant 4'b0111 -> XOR=1, so a word of 8'hFF is pushed every 8 cycles.
  - With REP_LIMIT=16 this trips health_fail on the 16th bit, and only the first 8'hFF is pushed.
  - Rerun with REP_LIMIT=64 and out_ready=0: after 4 words fifo_count=4; the 5th word sets overflow=1 and fifo_count stays 4.
- Health recovery: after the trip above, pulse clr_fail and toggle ch0 alternately in mode 0 -> health_fail=0, overflow=0, 8'hAA or 8'h55 words resume.
- Simultaneous push/pop when full: FIFO full, out_ready=1 on the cycle a word completes -> fifo_count stays 4, no overflow, data order preserved.

Source files
------------

// File: rtl/trng_harvester.sv
// Entropy harvester: synchronises biased oscillator outputs, conditions them (raw / XOR / von Neumann),
// packs bits into words, runs a sticky repetition-count health test and buffers words in a small FIFO.
module trng_harvester #(
    parameter int NUM_CH      = 4,
    parameter int WORD_W      = 8,
    parameter int SYNC_STAGES = 2,
    parameter int FIFO_DEPTH  = 4,
    parameter int REP_LIMIT   = 16
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          en,
    input  logic [1:0]                    mode,
    input  logic [NUM_CH-1:0]             raw_in,
    input  logic                          clr_fail,
    output logic [WORD_W-1:0]             out_data,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
    output logic                          health_fail,
    output logic                          overflow
);

    localparam int CW = $clog2(FIFO_DEPTH) + 1;
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int RW = $clog2(REP_LIMIT + 1);
    localparam int BW = (WORD_W > 2) ? $clog2(WORD_W) : 1;

    localparam logic [1:0] MODE_RAW = 2'd0;
    localparam logic [1:0] MODE_VN  = 2'd2;

    logic [NUM_CH-1:0] sync_q [SYNC_STAGES];
    logic [NUM_CH-1:0] s;
    logic [1:0]        mode_q;
    logic              vn_phase;
    logic              vn_bit;
    logic [RW-1:0]     rep_cnt;
    logic              last_b;
    logic [BW-1:0]     bit_cnt;
    logic [WORD_W-2:0] sr;

    logic [WORD_W-1:0] mem [FIFO_DEPTH];
    logic [PW-1:0]     wr_ptr;
    logic [PW-1:0]     rd_ptr;

    logic              mode_chg;
    logic              gen_ok;
    logic              emit;
    logic              b;
    logic [RW-1:0]     rep_next;
    logic              trip;
    logic              word_done;
    logic [WORD_W-1:0] word;
    logic              push;
    logic              pop;
    logic              full;
    logic              push_ok;
    logic              drop;
    logic [PW-1:0]     rd_ptr_next;
    logic [CW-1:0]     left;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
        end else begin
            sync_q[0] <= raw_in;
            for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
        end
    end

    assign s        = sync_q[SYNC_STAGES-1];
    assign mode_chg = (mode != mode_q);
    // Generation is suppressed while the health test is tripped, while clearing, and on a mode switch.
    assign gen_ok   = en & ~health_fail & ~clr_fail & ~mode_chg;

    always_comb begin
        emit = 1'b0;
        b    = 1'b0;
        case (mode)
            MODE_RAW: begin
                emit = gen_ok;
                b    = s[0];
            end
            MODE_VN: begin
                emit = gen_ok & vn_phase & (s[0] != vn_bit);
                b    = vn_bit;
            end
            default: begin
                emit = gen_ok;
                b    = ^s;
            end
        endcase
    end

    always_comb begin
        rep_next = RW'(1);
        if (rep_cnt != '0 && b == last_b) rep_next = rep_cnt + RW'(1);
    end

    assign trip      = emit & (rep_next == RW'(REP_LIMIT));
    assign word_done = emit & (bit_cnt == BW'(WORD_W - 1));
    assign word      = {sr, b};
    assign push      = word_done & ~trip;

    assign out_valid   = (fifo_count != '0);
    assign pop         = out_valid & out_ready;
    assign full        = (fifo_count == CW'(FIFO_DEPTH));
    assign push_ok     = push & (~full | pop);
    assign drop        = push & ~push_ok;
    assign rd_ptr_next = rd_ptr + PW'(pop);
    assign left        = pop ? fifo_count - CW'(1) : fifo_count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mode_q      <= '0;
            vn_phase    <= 1'b0;
            vn_bit      <= 1'b0;
            rep_cnt     <= '0;
            last_b      <= 1'b0;
            bit_cnt     <= '0;
            sr          <= '0;
            health_fail <= 1'b0;
            overflow    <= 1'b0;
        end else begin
            mode_q <= mode;
            if (clr_fail) begin
                health_fail <= 1'b0;
                overflow    <= 1'b0;
                rep_cnt     <= '0;
                bit_cnt     <= '0;
                vn_phase    <= 1'b0;
            end else begin
                if (drop) overflow <= 1'b1;
                if (trip) health_fail <= 1'b1;
                if (mode_chg) begin
                    bit_cnt  <= '0;
                    vn_phase <= 1'b0;
                    rep_cnt  <= '0;
                end else if (!en) begin
                    vn_phase <= 1'b0;
                end else if (!health_fail) begin
                    if (mode == MODE_VN) begin
                        vn_phase <= ~vn_phase;
                        if (!vn_phase) vn_bit <= s[0];
                    end
                    if (emit) begin
                        rep_cnt <= rep_next;
                        last_b  <= b;
                        sr      <= word[WORD_W-2:0];
                        // A trip throws away the partial word along with the completing bit.
                        if (trip || word_done) bit_cnt <= '0;
                        else                   bit_cnt <= bit_cnt + BW'(1);
                    end
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok) mem[wr_ptr] <= word;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
            out_data   <= '0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + PW'(1);
            rd_ptr     <= rd_ptr_next;
            fifo_count <= fifo_count + CW'(push_ok) - CW'(pop);
            // Head register: the next resident entry, or the word being pushed into an emptying FIFO.
            if (left != '0)   out_data <= mem[rd_ptr_next];
            else if (push_ok) out_data <= word;
        end
    end

endmodule

// File: tb/tb_trng_harvester.sv
// Directed bench for trng_harvester with a queue-based reference model checked every cycle.
module tb_trng_harvester;

    localparam int NUM_CH = 4;
    localparam int WORD_W = 8;
    localparam int SYNC   = 2;
    localparam int DEPTH  = 4;
    localparam int REP    = 16;

    logic              clk;
    logic              rst_n;
    logic              en;
    logic [1:0]        mode;
    logic [NUM_CH-1:0] raw_in;
    logic              clr_fail;
    logic [WORD_W-1:0] out_data;
    logic              out_valid;
    logic              out_ready;
    logic [2:0]        fifo_count;
    logic              health_fail;
    logic              overflow;

    trng_harvester #(
        .NUM_CH(NUM_CH), .WORD_W(WORD_W), .SYNC_STAGES(SYNC),
        .FIFO_DEPTH(DEPTH), .REP_LIMIT(REP)
    ) dut (
        .clk(clk), .rst_n(rst_n), .en(en), .mode(mode), .raw_in(raw_in),
        .clr_fail(clr_fail), .out_data(out_data), .out_valid(out_valid),
        .out_ready(out_ready), .fifo_count(fifo_count),
        .health_fail(health_fail), .overflow(overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    int valid_cycles = 0;
    logic [WORD_W-1:0] got_q [$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Reference model state
    logic [NUM_CH-1:0] m_pipe [$];
    logic [1:0]        m_mode;
    bit                m_hf, m_ovf, m_last, m_vn_phase, m_vn_bit;
    int                m_rep;
    bit                m_bits [$];
    logic [WORD_W-1:0] m_fifo [$];
    logic [WORD_W-1:0] m_data;

    task automatic model_step();
        logic [NUM_CH-1:0] s;
        logic [WORD_W-1:0] w;
        bit emit, b, pop, push;
        s = m_pipe.pop_front();
        m_pipe.push_back(raw_in);
        pop  = (m_fifo.size() > 0) && out_ready;
        emit = 0; b = 0; push = 0; w = '0;
        if (clr_fail) begin
            m_hf = 0; m_ovf = 0; m_rep = 0; m_vn_phase = 0;
            m_bits.delete();
        end else if (mode != m_mode) begin
            m_bits.delete(); m_vn_phase = 0; m_rep = 0;
        end else if (!en) begin
            m_vn_phase = 0;
        end else if (!m_hf) begin
            if (mode == 2'd2) begin
                if (!m_vn_phase) m_vn_bit = s[0];
                else if (s[0] != m_vn_bit) begin emit = 1; b = m_vn_bit; end
                m_vn_phase = !m_vn_phase;
            end else if (mode == 2'd0) begin
                emit = 1; b = s[0];
            end else begin
                emit = 1; b = ^s;
            end
            if (emit) begin
                if (m_rep == 0 || b != m_last) m_rep = 1;
                else m_rep++;
                m_last = b;
                m_bits.push_back(b);
                if (m_rep == REP) begin
                    m_hf = 1;
                    m_bits.delete();
                end else if (m_bits.size() == WORD_W) begin
                    foreach (m_bits[k]) w = {w[WORD_W-2:0], m_bits[k]};
                    push = 1;
                    m_bits.delete();
                end
            end
        end
        m_mode = mode;
        if (pop) void'(m_fifo.pop_front());
        if (push) begin
            if (m_fifo.size() < DEPTH) m_fifo.push_back(w);
            else m_ovf = 1;
        end
        if (m_fifo.size() > 0) m_data = m_fifo[0];
    endtask

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_pipe.delete();
            for (int i = 0; i < SYNC; i++) m_pipe.push_back('0);
            m_mode = 0; m_hf = 0; m_ovf = 0; m_last = 0; m_vn_phase = 0; m_vn_bit = 0;
            m_rep = 0; m_bits.delete(); m_fifo.delete(); m_data = '0;
        end else begin
            model_step();
        end
    end

    always @(negedge clk) begin
        if (rst_n) begin
            check("out_valid", out_valid, m_fifo.size() > 0);
            check("fifo_count", fifo_count, m_fifo.size());
            check("health_fail", health_fail, m_hf);
            check("overflow", overflow, m_ovf);
            check("out_data", out_data, m_data);
            if (out_valid) valid_cycles++;
            if (out_valid && out_ready) got_q.push_back(out_data);
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not reach the end");
        $fatal(1);
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic clr();
        clr_fail = 1'b1;
        cyc();
        clr_fail = 1'b0;
    endtask

    // Drive n bits MSB-first on ch0, with en aligned so exactly those bits reach the conditioner.
    task automatic feed(input logic [63:0] v, input int n, input bit rdy, input int rdy_at);
        for (int i = 0; i < n + SYNC; i++) begin
            raw_in    = {{(NUM_CH-1){1'b0}}, (i < n) ? v[n-1-i] : 1'b0};
            en        = (i >= SYNC);
            out_ready = (rdy_at < 0) ? rdy : (i == rdy_at + SYNC);
            cyc();
        end
        en = 1'b0;
    endtask

    task automatic wait_words(input string name, input int n);
        for (int c = 0; c < 60 && got_q.size() < n; c++) cyc();
        check(name, got_q.size(), n);
    endtask

    function automatic logic [WORD_W-1:0] got(input int idx);
        return (idx < got_q.size()) ? got_q[idx] : 'x;
    endfunction

    initial begin
        rst_n = 1'b0; en = 1'b0; mode = 2'd0; raw_in = '0; clr_fail = 1'b0; out_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_valid", out_valid, 0);
        check("rst_data", out_data, 0);
        check("rst_count", fifo_count, 0);
        check("rst_hf", health_fail, 0);
        check("rst_ovf", overflow, 0);
        rst_n = 1'b1;
        cyc();

        // Raw packing
        got_q.delete();
        valid_cycles = 0;
        feed(64'hB2, 8, 1'b1, -1);
        wait_words("raw_count", 1);
        repeat (3) cyc();
        check("raw_word", got(0), 8'hB2);
        check("raw_valid_cycles", valid_cycles, 1);

        // Von Neumann: 01 10 11 00 10 01 01 10 10 01
        mode = 2'd2;
        cyc(); cyc();
        clr();
        got_q.delete();
        feed(64'h6C969, 20, 1'b1, -1);
        wait_words("vn_count", 1);
        check("vn_word", got(0), 8'h66);

        // XOR of constant 0111 trips the repetition test on the 16th bit
        mode = 2'd1;
        raw_in = 4'b0111;
        repeat (SYNC + 2) cyc();
        clr();
        got_q.delete();
        en = 1'b1;
        repeat (24) cyc();
        en = 1'b0;
        cyc();
        check("xor_count", got_q.size(), 1);
        check("xor_word", got(0), 8'hFF);
        check("xor_trip", health_fail, 1);

        // Recovery in raw mode with alternating ch0
        mode = 2'd0;
        cyc(); cyc();
        clr();
        check("clr_hf", health_fail, 0);
        check("clr_ovf", overflow, 0);
        got_q.delete();
        feed(64'hAAAA, 16, 1'b1, -1);
        wait_words("rec_count", 2);
        check("rec_word0", got(0), 8'hAA);
        check("rec_word1", got(1), 8'hAA);

        // Overflow: five words with no consumer
        clr();
        got_q.delete();
        feed(64'h123456789A, 40, 1'b0, -1);
        cyc();
        check("ovf_count", fifo_count, 4);
        check("ovf_flag", overflow, 1);
        check("ovf_head", out_data, 8'h12);

        // Full FIFO with a pop on the completing cycle
        clr();
        check("full_ovf_cleared", overflow, 0);
        got_q.delete();
        feed(64'hBC, 8, 1'b0, 7);
        out_ready = 1'b0;
        check("full_pp_count", fifo_count, 4);
        check("full_pp_ovf", overflow, 0);
        out_ready = 1'b1;
        wait_words("full_drain_count", 5);
        check("full_order0", got(0), 8'h12);
        check("full_order1", got(1), 8'h34);
        check("full_order2", got(2), 8'h56);
        check("full_order3", got(3), 8'h78);
        check("full_order4", got(4), 8'hBC);

        // Asynchronous reset mid-operation: three words queued, five bits in the packer
        clr();
        out_ready = 1'b0;
        feed({8'h5A, 8'hC3, 8'h96, 5'b10110}, 29, 1'b0, -1);
        check("pre_rst_count", fifo_count, 3);
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        check("arst_valid", out_valid, 0);
        check("arst_data", out_data, 0);
        check("arst_count", fifo_count, 0);
        check("arst_hf", health_fail, 0);
        check("arst_ovf", overflow, 0);
        cyc();
        rst_n = 1'b1;
        repeat (6) cyc();
        check("post_rst_count", fifo_count, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
